lockstep_compare_monitor: RTL and testbench

Synthesizable lockstep checker that compares NUM_CH fabric output channels against golden-model channels cycle by cycle. After a configurable warm-up window it counts mismatches, records the first failing cycle and channel, and reports pass/fail. It sits in the user-project wrapper beside the eFPGA top and the gold reference, replacing bench-only compare loops so the same check runs in emulation and silicon bring-up.

---
 rtl/lockstep_pkg.sv | 22 ++
 rtl/lockstep_lane_cmp.sv | 27 ++
 rtl/lockstep_compare_monitor.sv | 188 ++++++++++++++++++
 tb/tb_lockstep_compare_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and defaults for the lockstep compare monitor.
// Used by lockstep_lane_cmp and lockstep_compare_monitor.
package lockstep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CH_W        = 36;
   localparam int DEF_CYC_W       = 16;
   localparam int DEF_SKIP_CYCLES = 5;

   // Channel-index width; never below one bit so a single channel still has a port.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lockstep_lane_cmp.sv
// One-channel comparator: mismatch flag and masked XOR vector.
// The XOR output exists only when LOCKSTEP_DIFF_ACCUM_EN is defined.
module lockstep_lane_cmp
   import lockstep_pkg::*;
#(
   parameter int CH_W = DEF_CH_W
) (
   input  logic [CH_W-1:0] dut_i,
   input  logic [CH_W-1:0] gold_i,
   input  logic            en_i,
   output logic            mis_o
`ifdef LOCKSTEP_DIFF_ACCUM_EN
   ,
   output logic [CH_W-1:0] xor_o
`endif
);

   logic [CH_W-1:0] diff;

   assign diff  = dut_i ^ gold_i;
   assign mis_o = en_i & (|diff);

`ifdef LOCKSTEP_DIFF_ACCUM_EN
   assign xor_o = en_i ? diff : '0;
`endif

endmodule

// File: rtl/lockstep_compare_monitor.sv
// Lockstep checker: registers dut/gold channels, skips a warm-up window, then
// counts failing cycles and records the first failure. LOCKSTEP_DIFF_ACCUM_EN adds diff_accum.
module lockstep_compare_monitor
   import lockstep_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CH_W        = DEF_CH_W,
   parameter int CYC_W       = DEF_CYC_W,
   parameter int SKIP_CYCLES = DEF_SKIP_CYCLES
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CYC_W-1:0]             run_cycles,
   input  logic [NUM_CH-1:0]            ch_mask,
   input  logic [NUM_CH*CH_W-1:0]       dut_data,
   input  logic [NUM_CH*CH_W-1:0]       gold_data,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [CYC_W-1:0]             err_count,
   output logic [CYC_W-1:0]             first_err_cycle,
   output logic [ch_idx_w(NUM_CH)-1:0]  first_err_ch,
   output logic                         err_seen
`ifdef LOCKSTEP_DIFF_ACCUM_EN
   ,
   output logic [CH_W-1:0]              diff_accum
`endif
);

   localparam int IDX_W = ch_idx_w(NUM_CH);
   localparam logic [CYC_W-1:0] SKIP_LAST = CYC_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);

   state_e                      state_q, state_d;
   logic [NUM_CH-1:0][CH_W-1:0] dut_q, gold_q;
   logic [NUM_CH-1:0]           mask_q, mask_d;
   logic [CYC_W-1:0]            run_q, run_d;
   logic [CYC_W-1:0]            cnt_q, cnt_d;
   logic [CYC_W-1:0]            err_cnt_q, err_cnt_d;
   logic [CYC_W-1:0]            first_cyc_q, first_cyc_d;
   logic [IDX_W-1:0]            first_ch_q, first_ch_d;
   logic                        err_seen_q, err_seen_d;

   logic [NUM_CH-1:0]           lane_mis;
   logic [IDX_W-1:0]            fail_idx;
   logic                        cyc_fail;

`ifdef LOCKSTEP_DIFF_ACCUM_EN
   logic [NUM_CH-1:0][CH_W-1:0] lane_xor;
   logic [CH_W-1:0]             xor_or;
   logic [CH_W-1:0]             diff_q, diff_d;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      lockstep_lane_cmp #(.CH_W(CH_W)) u_cmp (
         .dut_i  (dut_q[k]),
         .gold_i (gold_q[k]),
         .en_i   (mask_q[k]),
         .mis_o  (lane_mis[k])
`ifdef LOCKSTEP_DIFF_ACCUM_EN
         ,
         .xor_o  (lane_xor[k])
`endif
      );
   end

   assign cyc_fail = |lane_mis;

   // Lowest failing channel wins.
   always_comb begin
      fail_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (lane_mis[k]) fail_idx = IDX_W'(k);
   end

`ifdef LOCKSTEP_DIFF_ACCUM_EN
   always_comb begin
      xor_or = '0;
      for (int k = 0; k < NUM_CH; k++)
         xor_or = xor_or | lane_xor[k];
   end
`endif

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      run_d       = run_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      first_cyc_d = first_cyc_q;
      first_ch_d  = first_ch_q;
      err_seen_d  = err_seen_q;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
      diff_d      = diff_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               run_d       = run_cycles;
               mask_d      = ch_mask;
               cnt_d       = '0;
               err_cnt_d   = '0;
               first_cyc_d = '0;
               first_ch_d  = '0;
               err_seen_d  = 1'b0;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
               diff_d      = '0;
`endif
               if (SKIP_CYCLES != 0)      state_d = ST_WARMUP;
               else if (run_cycles == '0) state_d = ST_DONE;
               else                       state_d = ST_CHECK;
            end
         end
         ST_WARMUP: begin
            if (cnt_q == SKIP_LAST) begin
               cnt_d   = '0;
               state_d = (run_q == '0) ? ST_DONE : ST_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            if (cyc_fail) begin
               if (!err_seen_q) begin
                  first_cyc_d = cnt_q;
                  first_ch_d  = fail_idx;
                  err_seen_d  = 1'b1;
               end
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
`ifdef LOCKSTEP_DIFF_ACCUM_EN
            diff_d = diff_q | xor_or;
`endif
            if (cnt_q == run_q - 1'b1) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dut_q       <= '0;
         gold_q      <= '0;
         mask_q      <= '0;
         run_q       <= '0;
         cnt_q       <= '0;
         err_cnt_q   <= '0;
         first_cyc_q <= '0;
         first_ch_q  <= '0;
         err_seen_q  <= 1'b0;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
         diff_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         dut_q       <= dut_data;
         gold_q      <= gold_data;
         mask_q      <= mask_d;
         run_q       <= run_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_cyc_q <= first_cyc_d;
         first_ch_q  <= first_ch_d;
         err_seen_q  <= err_seen_d;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
         diff_q      <= diff_d;
`endif
      end
   end

   assign busy            = (state_q == ST_WARMUP) || (state_q == ST_CHECK);
   assign done            = (state_q == ST_DONE);
   assign pass            = done && (err_cnt_q == '0);
   assign err_count       = err_cnt_q;
   assign first_err_cycle = first_cyc_q;
   assign first_err_ch    = first_ch_q;
   assign err_seen        = err_seen_q;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
   assign diff_accum      = diff_q;
`endif

endmodule

// File: tb/tb_lockstep_compare_monitor.sv
// Randomized scoreboard bench for lockstep_compare_monitor; covers the
// LOCKSTEP_DIFF_ACCUM_EN output when that macro is defined.
module tb_lockstep_compare_monitor;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 36;
   localparam int CYC_W  = 16;
   localparam int SKIP   = 5;
   localparam int MAXR   = 256;

   logic                       CLK = 1'b0;
   logic                       reset;
   logic                       start;
   logic [CYC_W-1:0]           run_cycles;
   logic [NUM_CH-1:0]          ch_mask;
   logic [NUM_CH*CH_W-1:0]     dut_data, gold_data;
   logic                       busy, done, pass, err_seen;
   logic [CYC_W-1:0]           err_count, first_err_cycle;
   logic [1:0]                 first_err_ch;
`ifdef LOCKSTEP_DIFF_ACCUM_EN
   logic [CH_W-1:0]            diff_accum;
`endif

   lockstep_compare_monitor #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .CYC_W(CYC_W), .SKIP_CYCLES(SKIP)
   ) dut (
      .CLK(CLK), .reset(reset), .start(start), .run_cycles(run_cycles),
      .ch_mask(ch_mask), .dut_data(dut_data), .gold_data(gold_data),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_cycle(first_err_cycle), .first_err_ch(first_err_ch),
      .err_seen(err_seen)
`ifdef LOCKSTEP_DIFF_ACCUM_EN
      ,
      .diff_accum(diff_accum)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int              st;
      int              lat;
      logic [CYC_W-1:0] ec;
      logic [CYC_W-1:0] fc;
      logic [1:0]      fch;
      logic            ps;
      logic            es;
      logic [CH_W-1:0] diff;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every rising edge of done retires one expected run result.
   logic mon_prev = 1'b0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge CLK);
         if (done && !mon_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency",         64'(cyc - mon_e.st), 64'(mon_e.lat));
               chk("pass",            pass,            mon_e.ps);
               chk("err_count",       err_count,       mon_e.ec);
               chk("err_seen",        err_seen,        mon_e.es);
               chk("first_err_cycle", first_err_cycle, mon_e.fc);
               chk("first_err_ch",    first_err_ch,    mon_e.fch);
`ifdef LOCKSTEP_DIFF_ACCUM_EN
               chk("diff_accum",      diff_accum,      mon_e.diff);
`endif
            end
         end
         mon_prev = done;
      end
   end

   function automatic logic [CH_W-1:0] onehot(input int b);
      logic [CH_W-1:0] one;
      one = 1;
      return one << b;
   endfunction

   // mode: 0 identical, 1 ch2 bit0 @10,11, 2 ch1+ch3 @0, 3 persistent ch0,
   //       4 sparse random, 5 ch0 bit5 @3 and ch3 bit35 @7
   task automatic do_run(input int run, input logic [NUM_CH-1:0] mask, input int mode,
                         input int busy_at, input int abort_at, input bit end_start);
      logic [CH_W-1:0] fl [0:MAXR-1][0:NUM_CH-1];
      logic [63:0]     r64;
      logic [CH_W-1:0] g, f;
      exp_t            e;
      bit              anyf, aborted;
      int              idx, last, i;

      for (int c = 0; c < run; c++)
         for (int k = 0; k < NUM_CH; k++) begin
            case (mode)
               1: fl[c][k] = (k == 2 && (c == 10 || c == 11)) ? onehot(0) : '0;
               2: fl[c][k] = (c == 0 && (k == 1 || k == 3)) ? onehot($urandom_range(0, CH_W-1)) : '0;
               3: fl[c][k] = (k == 0) ? onehot($urandom_range(0, CH_W-1)) : '0;
               4: fl[c][k] = ($urandom_range(0, 7) == 0) ? onehot($urandom_range(0, CH_W-1)) : '0;
               5: fl[c][k] = (c == 3 && k == 0) ? onehot(5) : (c == 7 && k == 3) ? onehot(35) : '0;
               default: fl[c][k] = '0;
            endcase
         end

      // Reference result straight from the per-cycle flip table.
      e = '{st: 0, lat: SKIP + run + 1, ec: '0, fc: '0, fch: '0, ps: 1'b1, es: 1'b0, diff: '0};
      for (int c = 0; c < run; c++) begin
         anyf = 1'b0;
         idx  = 0;
         for (int k = NUM_CH - 1; k >= 0; k--)
            if (mask[k] && fl[c][k] != '0) begin
               anyf = 1'b1;
               idx  = k;
               e.diff = e.diff | fl[c][k];
            end
         if (anyf) begin
            if (!e.es) begin
               e.es  = 1'b1;
               e.fc  = CYC_W'(c);
               e.fch = 2'(idx);
            end
            if (e.ec != '1) e.ec = e.ec + 1'b1;
         end
      end
      e.ps = (e.ec == '0);

      last    = SKIP + run;
      aborted = 1'b0;
      for (int k = 0; k <= last; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            e.st = cyc;
            if (abort_at < 0) sb.push_back(e);
         end
         if (k == 1) chk("busy_in_run", busy, 1);
         if (abort_at >= 0 && k == SKIP + 1 + abort_at) begin
            reset   = 1'b1;
            aborted = 1'b1;
            break;
         end
         start      = (k == 0) || (k == busy_at) || (end_start && k == last);
         run_cycles = (k == 0) ? CYC_W'(run) : CYC_W'($urandom_range(0, 300));
         ch_mask    = (k == 0) ? mask : ~mask;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r64 = {$urandom(), $urandom()};
            g   = r64[CH_W-1:0];
            i   = k - SKIP;
            f   = (i >= 0 && i < run) ? fl[i][ch] : onehot($urandom_range(0, CH_W-1));
            gold_data[ch*CH_W +: CH_W] = g;
            dut_data[ch*CH_W +: CH_W]  = g ^ f;
         end
      end

      if (aborted) begin
         @(negedge CLK);
         chk("abort_busy",     busy,            0);
         chk("abort_done",     done,            0);
         chk("abort_pass",     pass,            0);
         chk("abort_errcnt",   err_count,       0);
         chk("abort_firstcyc", first_err_cycle, 0);
         chk("abort_firstch",  first_err_ch,    0);
         chk("abort_errseen",  err_seen,        0);
         reset = 1'b0;
         return;
      end

      @(negedge CLK);
      start = 1'b0;
      chk("done_after_run", done, 1);
      if (end_start) begin
         @(negedge CLK);
         chk("end_start_done",   done,      1);
         chk("end_start_errcnt", err_count, e.ec);
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      run_cycles = '0;
      ch_mask    = '0;
      dut_data   = '0;
      gold_data  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy",     busy,            0);
      chk("rst_done",     done,            0);
      chk("rst_pass",     pass,            0);
      chk("rst_errcnt",   err_count,       0);
      chk("rst_firstcyc", first_err_cycle, 0);
      chk("rst_firstch",  first_err_ch,    0);
      chk("rst_errseen",  err_seen,        0);
      reset = 1'b0;

      do_run(100, 4'hF,    0, -1, -1, 0);
      do_run(100, 4'hF,    1, -1, -1, 0);
      do_run(100, 4'hF,    2, -1, -1, 0);
      do_run(100, 4'b1110, 3, -1, -1, 0);
      do_run(100, 4'hF,    3, -1, -1, 0);
      do_run(100, 4'hF,    4, 50, -1, 0);
      do_run(100, 4'hF,    3, -1, 30, 0);
      do_run(100, 4'hF,    0, -1, -1, 0);
      do_run(0,   4'hF,    4, -1, -1, 0);
      do_run(60,  4'h0,    4, -1, -1, 0);
      do_run(40,  4'hF,    5, -1, -1, 1);
      for (int r = 0; r < 6; r++)
         do_run($urandom_range(1, 80), 4'($urandom_range(0, 15)), 4, -1, -1, bit'($urandom_range(0, 1)));

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", 64'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
